// File: rtl/axis_frame_tx_pkg.sv
// rtl/axis_frame_tx_pkg.sv - shared types and width helpers for the frame transmitter
//
// Purpose: FSM state type, default depth, and index/length width helpers used
//          by the transmitter top, its buffer and its stream interface.
// Ports:   none (package).
package axis_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } frame_tx_state_t;

  localparam int TX_DEPTH = 16;

  // Buffer index width: addresses words 0..depth-1.
  function automatic int tx_idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Length width: one extra bit so a full-depth frame length is representable.
  function automatic int tx_len_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_frame_transmitter_if.sv
// rtl/axis_frame_transmitter_if.sv - stream interface carried by the frame transmitter
//
// Purpose: one stream channel with per-beat data, destination, user sideband and
//          end-of-frame marker.
// Ports:   master drives tvalid/tdata/tdest/tuser/tlast and samples tready;
//          slave is the mirror image.
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 32,
  parameter int USER_WIDTH = 32
) ();

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tdest,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tdest,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_frame_transmitter_buffer.sv
// rtl/axis_frame_transmitter_buffer.sv - frame word storage for the transmitter
//
// Purpose: DEPTH x DATA_WIDTH register file holding the frame to be sent.
//          Contents survive reset; software reloads them as needed.
// Ports:   clock                          write clock
//          wr_en / wr_addr / wr_data      synchronous write port
//          rd_addr / rd_data              combinational read port
module frame_tx_buffer
  import axis_frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = TX_DEPTH
) (
  input  logic                            clock,
  input  logic                            wr_en,
  input  logic [tx_idx_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [tx_idx_width(DEPTH)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]           rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_frame_transmitter.sv
// rtl/axis_frame_transmitter.sv - sends a software-loaded frame on a stream master port
//
// Purpose: frame words are written into a local buffer, then start launches
//          1..DEPTH words out of axis_out with tlast on the final word and a
//          per-frame dest/user held constant for the whole frame.
// Ports:   clock, reset (synchronous, active-low)
//          wr_en/wr_addr/wr_data   buffer load port (dropped while busy)
//          frame_length/dest/user  frame descriptor, sampled on accepted start
//          start                   launch request (ignored while busy)
//          busy                    frame in flight
//          done                    one-cycle completion pulse
//          axis_out                stream master
module axis_frame_transmitter
  import axis_frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int DEPTH      = TX_DEPTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [tx_idx_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [tx_len_width(DEPTH)-1:0]  frame_length,
  input  logic [DEST_WIDTH-1:0]           frame_dest,
  input  logic [USER_WIDTH-1:0]           frame_user,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  axi_stream.master                       axis_out
);

  localparam int IDX_W = tx_idx_width(DEPTH);
  localparam int LEN_W = tx_len_width(DEPTH);

  frame_tx_state_t state_q, state_d;

  logic [LEN_W-1:0]      len_q,   len_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [DEST_WIDTH-1:0] dest_q,  dest_d;
  logic [USER_WIDTH-1:0] user_q,  user_d;
  logic                  tlast_q, tlast_d;

  logic                  buf_wr_en;
  logic [IDX_W-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [LEN_W-1:0]      len_clamped;
  logic                  handshake;

  // The buffer is frozen for the whole frame: writes only land in IDLE.
  assign buf_wr_en = wr_en && (state_q == IDLE);

  // In IDLE the output stage preloads word 0; in SEND it preloads the word
  // after the one currently presented.
  assign rd_addr = (state_q == SEND) ? idx_q + IDX_W'(1) : '0;

  frame_tx_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buffer (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (buf_rd_data)
  );

  // A write landing in the same cycle as start must be seen by that frame, so
  // forward it around the register file.
  assign rd_word = (buf_wr_en && (wr_addr == rd_addr)) ? wr_data : buf_rd_data;

  assign len_clamped = (frame_length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : frame_length;
  assign handshake   = valid_q && axis_out.tready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      user_q  <= '0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      user_q  <= user_d;
      tlast_q <= tlast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    dest_d  = dest_q;
    user_d  = user_q;
    tlast_d = tlast_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_length == '0) begin
            state_d = FINISH;
          end else begin
            state_d = SEND;
            len_d   = len_clamped;
            dest_d  = frame_dest;
            user_d  = frame_user;
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = rd_word;
            tlast_d = (len_clamped == LEN_W'(1));
          end
        end
      end

      SEND: begin
        // valid stays high throughout SEND, so the output register only
        // reloads on a handshake.
        if (handshake) begin
          if (LEN_W'(idx_q) == len_q - LEN_W'(1)) begin
            state_d = FINISH;
            valid_d = 1'b0;
            tlast_d = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            data_d  = rd_word;
            tlast_d = (LEN_W'(idx_q) + LEN_W'(2) == len_q);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);

  assign axis_out.tvalid = valid_q;
  assign axis_out.tdata  = data_q;
  assign axis_out.tdest  = dest_q;
  assign axis_out.tuser  = user_q;
  assign axis_out.tlast  = tlast_q;

endmodule

// File: tb/tb_axis_frame_transmitter.sv
// tb/tb_axis_frame_transmitter.sv - directed self-checking bench for axis_frame_transmitter
module tb_axis_frame_transmitter;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [DW-1:0]    wr_data;
  logic [LEN_W-1:0] frame_length;
  logic [DW-1:0]    frame_dest;
  logic [DW-1:0]    frame_user;
  logic             start;
  logic             busy;
  logic             done;

  axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(DW), .USER_WIDTH(DW)) axis_if ();

  axis_frame_transmitter #(
    .DATA_WIDTH (DW),
    .DEST_WIDTH (DW),
    .USER_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_length (frame_length),
    .frame_dest   (frame_dest),
    .frame_user   (frame_user),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .axis_out     (axis_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Beats captured by capture(): data, tlast, dest, user and capture cycle.
  logic [DW-1:0] cap_data [0:31];
  logic          cap_last [0:31];
  logic [DW-1:0] cap_dest [0:31];
  logic [DW-1:0] cap_user [0:31];
  int            cap_cyc  [0:31];
  int            cap_n;
  int            cap_unstable;
  int            cap_done_at;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic launch(input int len, input logic [DW-1:0] dst, input logic [DW-1:0] usr);
    start        = 1'b1;
    frame_length = LEN_W'(len);
    frame_dest   = dst;
    frame_user   = usr;
    tick();
    start        = 1'b0;
  endtask

  // Drives tready (mode 0: always 1; mode 1: 1,0,0,1,0,1 repeating), records
  // every handshake and any change of a stalled beat, stops when done is seen.
  // At cycle inject_at, a stray write and start are driven for one cycle.
  task automatic capture(input int mode, input int budget, input int inject_at);
    logic          held;
    logic [DW-1:0] held_data;
    logic          held_last;
    cap_n        = 0;
    cap_unstable = 0;
    cap_done_at  = -1;
    held         = 1'b0;
    held_data    = '0;
    held_last    = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (held && (!axis_if.tvalid || axis_if.tdata !== held_data || axis_if.tlast !== held_last))
        cap_unstable++;
      if (done) begin
        cap_done_at = c;
        break;
      end
      if (c == inject_at) begin
        wr_en        = 1'b1;
        wr_addr      = IDX_W'(3);
        wr_data      = 32'hDEAD_BEEF;
        start        = 1'b1;
        frame_length = LEN_W'(2);
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      if (mode == 0) axis_if.tready = 1'b1;
      else           axis_if.tready = ((c % 6) == 0) || ((c % 6) == 3) || ((c % 6) == 5);
      if (axis_if.tvalid && axis_if.tready && cap_n < 32) begin
        cap_data[cap_n] = axis_if.tdata;
        cap_last[cap_n] = axis_if.tlast;
        cap_dest[cap_n] = axis_if.tdest;
        cap_user[cap_n] = axis_if.tuser;
        cap_cyc[cap_n]  = c;
        cap_n++;
      end
      held      = axis_if.tvalid && !axis_if.tready;
      held_data = axis_if.tdata;
      held_last = axis_if.tlast;
      tick();
    end
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", axis_if.tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (axis_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", axis_if.tlast); end
    checks++; if (axis_if.tdata !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", axis_if.tdata); end
    checks++; if (axis_if.tdest !== 32'h0 || axis_if.tuser !== 32'h0) begin errors++; $display("FAIL reset_dest_user got=%h/%h exp=0/0", axis_if.tdest, axis_if.tuser); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) load_word(i, 32'h10 + i);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_pre got=%b exp=0", busy); end
    axis_if.tready = 1'b1;
    launch(4, 32'd5, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_post got=%b exp=1", busy); end
    capture(0, 40, -1);
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", cap_n); end
    for (int k = 0; k < 4 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== 32'h10 + k || cap_last[k] !== (k == 3) || cap_dest[k] !== 32'd5 ||
          cap_user[k] !== 32'd7 || cap_cyc[k] !== k) begin
        errors++;
        $display("FAIL basic_beat%0d got=%h last=%b dest=%0d user=%0d cyc=%0d exp=%h last=%b dest=5 user=7 cyc=%0d",
                 k, cap_data[k], cap_last[k], cap_dest[k], cap_user[k], cap_cyc[k], 32'h10 + k, (k == 3), k);
      end
    end
    checks++; if (cap_done_at !== 4) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=4", cap_done_at); end
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got=%b exp=0", axis_if.tvalid); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got done=%b busy=%b exp=0/0", done, busy); end
  endtask

  task automatic test_backpressure();
    axis_if.tready = 1'b1;
    launch(4, 32'd5, 32'd7);
    capture(1, 60, -1);
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", cap_n); end
    for (int k = 0; k < 4 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== 32'h10 + k || cap_last[k] !== (k == 3)) begin
        errors++;
        $display("FAIL bp_beat%0d got=%h last=%b exp=%h last=%b", k, cap_data[k], cap_last[k], 32'h10 + k, (k == 3));
      end
    end
    checks++; if (cap_unstable !== 0) begin errors++; $display("FAIL bp_stable got=%0d changes exp=0", cap_unstable); end
    checks++; if (cap_done_at < 0) begin errors++; $display("FAIL bp_done got=timeout exp=done"); end
    tick();
  endtask

  task automatic test_zero_length();
    int valid_seen;
    valid_seen = 0;
    axis_if.tready = 1'b1;
    launch(0, 32'd1, 32'd2);
    if (axis_if.tvalid) valid_seen++;
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_done got done=%b busy=%b exp=1/1", done, busy); end
    tick();
    if (axis_if.tvalid) valid_seen++;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_end got done=%b busy=%b exp=0/0", done, busy); end
    tick();
    if (axis_if.tvalid) valid_seen++;
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL zero_novalid got=%0d beats exp=0", valid_seen); end
  endtask

  task automatic test_overlength();
    for (int i = 0; i < DEPTH; i++) load_word(i, 32'h40 + i);
    axis_if.tready = 1'b1;
    launch(DEPTH + 3, 32'd9, 32'd3);
    capture(0, 60, 5);
    checks++; if (cap_n !== DEPTH) begin errors++; $display("FAIL over_count got=%0d exp=%0d", cap_n, DEPTH); end
    for (int k = 0; k < DEPTH && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== 32'h40 + k || cap_last[k] !== (k == DEPTH - 1)) begin
        errors++;
        $display("FAIL over_beat%0d got=%h last=%b exp=%h last=%b", k, cap_data[k], cap_last[k], 32'h40 + k, (k == DEPTH - 1));
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL over_no_relaunch got busy=%b valid=%b exp=0/0", busy, axis_if.tvalid); end
    launch(4, 32'd9, 32'd3);
    capture(0, 40, -1);
    checks++; if (cap_n !== 4 || cap_data[3] !== 32'h43) begin errors++; $display("FAIL over_buffer_frozen got n=%0d word3=%h exp n=4 word3=00000043", cap_n, cap_data[3]); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 4; i++) load_word(i, 32'h50 + i);
    axis_if.tready = 1'b1;
    launch(4, 32'd4, 32'd4);
    tick();
    tick();
    axis_if.tready = 1'b0;
    checks++; if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== 32'h52) begin errors++; $display("FAIL rst_beat2 got valid=%b data=%h exp 1/00000052", axis_if.tvalid, axis_if.tdata); end
    reset = 1'b0;
    tick();
    checks++;
    if (axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got valid=%b tlast=%b busy=%b done=%b exp 0/0/0/0", axis_if.tvalid, axis_if.tlast, busy, done);
    end
    reset = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_after got done=%b busy=%b exp=0/0", done, busy); end
    axis_if.tready = 1'b1;
    launch(4, 32'd4, 32'd4);
    capture(0, 40, -1);
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL rst_resend_count got=%0d exp=4", cap_n); end
    for (int k = 0; k < 4 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== 32'h50 + k) begin errors++; $display("FAIL rst_resend%0d got=%h exp=%h", k, cap_data[k], 32'h50 + k); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    load_word(0, 32'h60);
    axis_if.tready = 1'b1;
    launch(1, 32'd6, 32'd6);
    capture(0, 20, -1);
    checks++; if (cap_n !== 1 || cap_data[0] !== 32'h60 || cap_last[0] !== 1'b1) begin errors++; $display("FAIL b2b_first got n=%0d data=%h last=%b exp 1/00000060/1", cap_n, cap_data[0], cap_last[0]); end
    checks++; if (cap_done_at !== 1) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=1", cap_done_at); end
    tick();
    checks++; if (axis_if.tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_gap got valid=%b busy=%b exp=0/0", axis_if.tvalid, busy); end
    // Rewrite word 0 in the same cycle as start: the frame must carry the new word.
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 32'h61;
    launch(1, 32'd8, 32'd8);
    wr_en   = 1'b0;
    checks++;
    if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== 32'h61 || axis_if.tlast !== 1'b1 || axis_if.tdest !== 32'd8) begin
      errors++;
      $display("FAIL b2b_second got valid=%b data=%h last=%b dest=%0d exp 1/00000061/1/8", axis_if.tvalid, axis_if.tdata, axis_if.tlast, axis_if.tdest);
    end
    tick();
    checks++; if (done !== 1'b1 || axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL b2b_second_done got done=%b valid=%b exp=1/0", done, axis_if.tvalid); end
    tick();
  endtask

  initial begin
    reset          = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    frame_length   = '0;
    frame_dest     = '0;
    frame_user     = '0;
    start          = 1'b0;
    axis_if.tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_overlength();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
